// File: rtl/spi_frame_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_frame_sender                                                           |
// | Mode-0 SPI master: one command byte plus a counted, flow-controlled        |
// | payload stream inside a single chip-select window.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_frame_sender #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  command,
    input  logic [15:0] length,
    input  logic        data_valid,
    input  logic [7:0]  data,
    output logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_cs
);

    // One shared counter serves the setup, SCK-phase and hold intervals.
    localparam int c_MAXC = (CLK_DIV > CS_SETUP)
                          ? ((CLK_DIV  > CS_HOLD) ? CLK_DIV  : CS_HOLD)
                          : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int c_CW = $clog2(c_MAXC + 1);
    localparam logic [c_CW-1:0] c_DIV_LAST   = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_SETUP_LAST = c_CW'(CS_SETUP - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST  = c_CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LOAD  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [15:0]     r_remaining;
    logic [7:0]      r_shift;
    logic            r_sck;
    logic            r_mosi;
    logic            r_cs;
    logic            r_busy;
    logic            r_done;
    logic            r_ready;
    logic            w_phase_end;

    assign w_phase_end = (r_cnt == c_DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_remaining <= 16'd0;
            r_shift     <= 8'd0;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_SETUP;
                        r_shift     <= command;
                        r_remaining <= length;
                        r_cs        <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                        r_bit   <= 3'd7;
                        r_mosi  <= r_shift[7];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!w_phase_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit != 3'd0) begin
                                // Next bit is presented at the start of its low phase.
                                r_bit   <= r_bit - 3'd1;
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_mosi  <= r_shift[6];
                            end else if (r_remaining != 16'd0) begin
                                r_state <= ST_LOAD;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= ST_HOLD;
                                r_cs    <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    // SCK is parked low here, so an empty source simply stretches the frame.
                    if (data_valid && r_ready) begin
                        r_state     <= ST_SHIFT;
                        r_ready     <= 1'b0;
                        r_shift     <= data;
                        r_mosi      <= data[7];
                        r_remaining <= r_remaining - 16'd1;
                        r_bit       <= 3'd7;
                        r_cnt       <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_mosi  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_ready = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign spi_clk    = r_sck;
    assign spi_mosi   = r_mosi;
    assign spi_cs     = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_frame_sender                                                        |
// | Self-checking bench: mode-0 receiver model, byte source and frame model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spi_frame_sender;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int TIMEOUT  = 5000;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  command;
    logic [15:0] length;
    logic        data_valid;
    logic [7:0]  data;
    logic        data_ready;
    logic        busy;
    logic        done;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_cs;

    spi_frame_sender #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .command    (command),
        .length     (length),
        .data_valid (data_valid),
        .data       (data),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Receiver/monitor state, sampled on the falling clock edge.
    int         pcyc = 0;
    int         rises, done_cnt, ready_cnt, busy_cnt, bad_load, bad_done;
    int         falls, low_run, high_run, last_low, fall_cyc, rise_cyc;
    int         nbits = 0;
    logic       prev_cs  = 1'b1;
    logic       prev_sck = 1'b0;
    logic [7:0] shreg    = 8'd0;
    logic [7:0] cap_q[$];
    int         gap_q[$];

    // Byte source and expected-frame model.
    logic [7:0] src_d[$];
    int         src_g[$];
    bit         hs_pending;
    logic [7:0] exp_q[$];
    int         exp_gaps;

    always @(posedge clock) pcyc <= pcyc + 1;

    always @(negedge clock) begin
        if (spi_cs == 1'b0 && prev_cs == 1'b1) begin
            gap_q.push_back(high_run);
            if (falls == 0) fall_cyc = pcyc;
            falls++;
            high_run = 0;
            low_run  = 0;
            nbits    = 0;
        end
        if (spi_cs == 1'b1 && prev_cs == 1'b0) last_low = low_run;
        if (spi_cs == 1'b0) low_run++;
        else high_run++;
        if (spi_clk == 1'b1 && prev_sck == 1'b0) begin
            if (rises == 0) rise_cyc = pcyc;
            rises++;
            if (spi_cs == 1'b0) begin
                shreg = {shreg[6:0], spi_mosi};
                nbits++;
                if (nbits == 8) begin
                    cap_q.push_back(shreg);
                    nbits = 0;
                end
            end
        end
        if (done == 1'b1) begin
            done_cnt++;
            if (!(spi_cs == 1'b1 && prev_cs == 1'b0)) bad_done++;
        end
        if (data_ready == 1'b1) begin
            ready_cnt++;
            if (spi_clk !== 1'b0 || spi_cs !== 1'b0) bad_load++;
        end
        if (busy == 1'b1) busy_cnt++;
        prev_cs  = spi_cs;
        prev_sck = spi_clk;
    end

    // Each queued byte is withheld for its gap count of data_ready cycles first.
    initial begin
        logic [7:0] d_tmp;
        int         g_tmp;
        data_valid = 1'b0;
        data       = 8'd0;
        hs_pending = 1'b0;
        forever begin
            @(negedge clock);
            if (hs_pending && src_d.size() > 0) begin
                d_tmp = src_d.pop_front();
                g_tmp = src_g.pop_front();
            end
            if (src_d.size() == 0) begin
                data_valid = 1'b0;
            end else if (src_g[0] > 0) begin
                data_valid = 1'b0;
                if (data_ready) src_g[0] = src_g[0] - 1;
            end else begin
                data_valid = 1'b1;
                data       = src_d[0];
            end
            hs_pending = data_valid && data_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic int exp_cs_low(input int len, input int gaps);
        return CS_SETUP + (1 + len) * 16 * CLK_DIV + len + gaps;
    endfunction

    task automatic clear_mon();
        rises = 0; done_cnt = 0; ready_cnt = 0; busy_cnt = 0; bad_load = 0;
        bad_done = 0; falls = 0; last_low = -1; fall_cyc = -1; rise_cyc = -1;
        cap_q.delete();
        gap_q.delete();
    endtask

    task automatic prep(input logic [7:0] cmd);
        exp_q.delete();
        src_d.delete();
        src_g.delete();
        exp_gaps = 0;
        exp_q.push_back(cmd);
    endtask

    task automatic push_payload(input logic [7:0] d, input int g);
        src_d.push_back(d);
        src_g.push_back(g);
        exp_q.push_back(d);
        exp_gaps += g;
    endtask

    // kind 0: plain frame; 1: stray start once rises reach at_rise; 2: return at at_rise.
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] len, input int kind,
                             input int at_rise, output bit to, output int st_cyc);
        int n;
        bit inj;
        to = 1'b0; inj = 1'b0; n = 0;
        @(posedge clock);
        clear_mon();
        @(negedge clock);
        command = cmd; length = len; start = 1'b1; st_cyc = pcyc;
        @(negedge clock);
        start = 1'b0; command = 8'($urandom); length = 16'($urandom);
        forever begin
            if (kind == 2 && rises >= at_rise) return;
            if (done_cnt > 0) break;
            if (n >= TIMEOUT) begin
                to = 1'b1;
                break;
            end
            if (kind == 1 && !inj && rises >= at_rise) begin
                command = 8'hFF; length = 16'd7; start = 1'b1; inj = 1'b1;
                @(negedge clock);
                start = 1'b0; n++;
            end
            @(negedge clock);
            n++;
        end
        repeat (CS_HOLD + 2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({spi_cs, spi_clk, spi_mosi, busy, data_ready, done} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got cs,sck,mosi,busy,ready,done=%b expected 100000",
                     {spi_cs, spi_clk, spi_mosi, busy, data_ready, done});
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({spi_cs, spi_clk, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got cs,sck,busy=%b expected 100", {spi_cs, spi_clk, busy});
        end
    endtask

    task automatic test_basic_frame();
        bit to;
        int st;
        prep(8'h01);
        for (int i = 0; i < 6; i++) push_payload(8'(8'h10 + i), 0);
        run_frame(8'h01, 16'd6, 0, 0, to, st);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL basic_timeout: no done within %0d cycles", TIMEOUT); end
        tests_run++;
        if (cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL basic_bytes: got %0d bytes expected %0d", cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (cap_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL basic_byte%0d: got %02h expected %02h", i, cap_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (rises != 56) begin tests_failed++; $display("FAIL basic_rises: got %0d expected 56", rises); end
        tests_run++;
        if (done_cnt != 1 || bad_done != 0) begin
            tests_failed++;
            $display("FAIL basic_done: got %0d pulses (%0d misaligned) expected 1", done_cnt, bad_done);
        end
        tests_run++;
        if (last_low != 232) begin tests_failed++; $display("FAIL basic_cs_low: got %0d expected 232", last_low); end
        tests_run++;
        if (busy_cnt != 232 + CS_HOLD) begin
            tests_failed++;
            $display("FAIL basic_busy: got %0d expected %0d", busy_cnt, 232 + CS_HOLD);
        end
        tests_run++;
        if (fall_cyc - st != 1) begin
            tests_failed++;
            $display("FAIL basic_cs_latency: got %0d expected 1", fall_cyc - st);
        end
        tests_run++;
        if (rise_cyc - st != 1 + CS_SETUP + CLK_DIV) begin
            tests_failed++;
            $display("FAIL basic_first_rise: got %0d expected %0d", rise_cyc - st, 1 + CS_SETUP + CLK_DIV);
        end
    endtask

    task automatic test_command_only();
        bit to;
        int st;
        prep(8'hA5);
        run_frame(8'hA5, 16'd0, 0, 0, to, st);
        tests_run++;
        if (to || cap_q.size() != 1 || cap_q[0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL cmd_only_data: got %0d bytes first %02h (timeout %0d) expected 1 byte a5",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'h00, to);
        end
        tests_run++;
        if (rises != 8) begin tests_failed++; $display("FAIL cmd_only_rises: got %0d expected 8", rises); end
        tests_run++;
        if (ready_cnt != 0) begin tests_failed++; $display("FAIL cmd_only_ready: got %0d expected 0", ready_cnt); end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("FAIL cmd_only_done: got %0d expected 1", done_cnt); end
        tests_run++;
        if (last_low != exp_cs_low(0, 0)) begin
            tests_failed++;
            $display("FAIL cmd_only_cs_low: got %0d expected %0d", last_low, exp_cs_low(0, 0));
        end
    endtask

    task automatic test_stall();
        bit to;
        int st;
        prep(8'h3C);
        for (int i = 0; i < 6; i++) push_payload(8'($urandom), (i == 3) ? 20 : 0);
        run_frame(8'h3C, 16'd6, 0, 0, to, st);
        tests_run++;
        if (to || cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d bytes (timeout %0d) expected %0d", cap_q.size(), to, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (cap_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL stall_byte%0d: got %02h expected %02h", i, cap_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (rises != 56) begin tests_failed++; $display("FAIL stall_rises: got %0d expected 56", rises); end
        tests_run++;
        if (bad_load != 0) begin
            tests_failed++;
            $display("FAIL stall_lines: got %0d load cycles with sck/cs active expected 0", bad_load);
        end
        tests_run++;
        if (ready_cnt != 6 + 20) begin tests_failed++; $display("FAIL stall_ready: got %0d expected 26", ready_cnt); end
        tests_run++;
        if (last_low != exp_cs_low(6, 20)) begin
            tests_failed++;
            $display("FAIL stall_cs_low: got %0d expected %0d", last_low, exp_cs_low(6, 20));
        end
    endtask

    task automatic test_ignored_start();
        bit to;
        int st;
        prep(8'h5A);
        for (int i = 0; i < 3; i++) push_payload(8'($urandom), 0);
        run_frame(8'h5A, 16'd3, 1, 20, to, st);
        repeat (60) @(negedge clock);
        tests_run++;
        if (to || cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL ignored_count: got %0d bytes (timeout %0d) expected %0d", cap_q.size(), to, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (cap_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL ignored_byte%0d: got %02h expected %02h", i, cap_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (falls != 1 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL ignored_frames: got %0d frames %0d done expected 1 and 1", falls, done_cnt);
        end
        tests_run++;
        if (last_low != exp_cs_low(3, 0)) begin
            tests_failed++;
            $display("FAIL ignored_cs_low: got %0d expected %0d", last_low, exp_cs_low(3, 0));
        end
    endtask

    task automatic test_reset_mid_frame();
        bit         to;
        int         st;
        logic [7:0] cmd;
        cmd = 8'($urandom);
        prep(cmd);
        for (int i = 0; i < 3; i++) push_payload(8'($urandom), 0);
        run_frame(cmd, 16'd3, 2, 12, to, st);
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if ({spi_cs, spi_clk, spi_mosi, busy, data_ready, done} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got cs,sck,mosi,busy,ready,done=%b expected 100000",
                     {spi_cs, spi_clk, spi_mosi, busy, data_ready, done});
        end
        reset = 1'b0;
        src_d.delete();
        src_g.delete();
        repeat (4) @(negedge clock);
        tests_run++;
        if (to || done_cnt != 0 || cap_q.size() != 1) begin
            tests_failed++;
            $display("FAIL midreset_partial: got %0d bytes %0d done (timeout %0d) expected 1 and 0",
                     cap_q.size(), done_cnt, to);
        end
        cmd = 8'($urandom);
        prep(cmd);
        for (int i = 0; i < 3; i++) push_payload(8'($urandom), 0);
        run_frame(cmd, 16'd3, 0, 0, to, st);
        tests_run++;
        if (to || cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL midreset_next_count: got %0d bytes (timeout %0d) expected %0d", cap_q.size(), to, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (cap_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL midreset_next_byte%0d: got %02h expected %02h", i, cap_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (rises != 32 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL midreset_next_frame: got %0d rises %0d done expected 32 and 1", rises, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cmd;
        int         n;
        cmd = 8'($urandom);
        prep(cmd);
        for (int f = 0; f < 3; f++) begin
            if (f > 0) exp_q.push_back(cmd);
            for (int i = 0; i < 2; i++) push_payload(8'($urandom), 0);
        end
        @(posedge clock);
        clear_mon();
        @(negedge clock);
        command = cmd; length = 16'd2; start = 1'b1;
        n = 0;
        while (done_cnt < 3 && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        repeat (CS_HOLD + 4) @(negedge clock);
        tests_run++;
        if (n >= TIMEOUT) begin tests_failed++; $display("FAIL b2b_timeout: got %0d done expected 3", done_cnt); end
        tests_run++;
        if (falls != 3 || done_cnt != 3) begin
            tests_failed++;
            $display("FAIL b2b_frames: got %0d frames %0d done expected 3 and 3", falls, done_cnt);
        end
        for (int f = 1; f < 3; f++) begin
            tests_run++;
            if (gap_q.size() <= f || gap_q[f] != CS_HOLD + 1) begin
                tests_failed++;
                $display("FAIL b2b_gap%0d: got %0d expected %0d", f, (gap_q.size() > f) ? gap_q[f] : -1, CS_HOLD + 1);
            end
        end
        tests_run++;
        if (cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d bytes expected %0d", cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (cap_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_byte%0d: got %02h expected %02h", i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit         to;
        int         st;
        int         len;
        logic [7:0] cmd;
        for (int f = 0; f < 4; f++) begin
            cmd = 8'($urandom);
            len = $urandom_range(0, 5);
            prep(cmd);
            for (int i = 0; i < len; i++) push_payload(8'($urandom), $urandom_range(0, 4));
            run_frame(cmd, 16'(len), 0, 0, to, st);
            tests_run++;
            if (to || cap_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_count: got %0d bytes (timeout %0d) expected %0d", f, cap_q.size(), to, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    tests_run++;
                    if (cap_q[i] !== exp_q[i]) begin
                        tests_failed++;
                        $display("FAIL rand%0d_byte%0d: got %02h expected %02h", f, i, cap_q[i], exp_q[i]);
                    end
                end
            end
            tests_run++;
            if (rises != 8 * (1 + len) || ready_cnt != len + exp_gaps) begin
                tests_failed++;
                $display("FAIL rand%0d_edges: got %0d rises %0d ready expected %0d and %0d",
                         f, rises, ready_cnt, 8 * (1 + len), len + exp_gaps);
            end
            tests_run++;
            if (last_low != exp_cs_low(len, exp_gaps) || done_cnt != 1) begin
                tests_failed++;
                $display("FAIL rand%0d_frame: got cs_low %0d done %0d expected %0d and 1",
                         f, last_low, done_cnt, exp_cs_low(len, exp_gaps));
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        command = 8'd0;
        length  = 16'd0;
        test_reset();
        test_basic_frame();
        test_command_only();
        test_stall();
        test_ignored_start();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
